dot_tracker: RTL
================

Name: dot_tracker

Overview:
- Game-state stage that consumes the per-pixel dot-kill and ghost-collision strobes produced by the colour mapper.
- Holds the authoritative dot-alive mask, score and win/lose state.
- Feeds alive_10 and the end-screen select back to the colour mapper.
- Decouples pixel-rate events from game state by accumulating strobes over a frame and committing them once per frame.

Parameters:
- NUM_DOTS, 10, number of collectible dots; width of kill/alive masks.
- SCORE_W, 4, score counter width; must satisfy 2**SCORE_W > NUM_DOTS.
- LIVES, 3, starting lives (used only with DOT_LIVES_EN).

Ports:
- Clk  in  1  system clock (pixel-domain clock).
- Reset_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- new_game  in  1  level request (keycode-derived); sampled in IDLE/WIN/LOSE.
- kill_10  in  NUM_DOTS  per-pixel dot-eaten strobes from colour mapper.
- ghost_hit  in  1  per-pixel pac/ghost overlap strobe from colour mapper.
- alive_10  out  NUM_DOTS  registered live-dot mask.
- score  out  SCORE_W  dots eaten this game.
- game_state  out  2  IDLE=0, PLAY=1, WIN=2, LOSE=3.
- end_screen  out  1  high in WIN or LOSE; colour mapper shows end font.
- lives  out  2  remaining lives (constant LIVES when feature absent).

Behaviour:
- Reset (async, Reset_n=0): alive_10 = all ones, score = 0, pending mask = 0, hit_pend = 0, state IDLE, end_screen = 0, lives = LIVES.
- Accumulation runs in PLAY only:
  - pending |= kill_10 every cycle.
  - hit_pend |= ghost_hit every cycle.
  - Strobes outside PLAY are ignored.
- Commit on a cycle with frame_start=1 in PLAY:
  - eaten = pending_next & alive_10, where pending_next includes the current cycle's kill_10.
  - alive_10 <= alive_10 & ~eaten.
  - score <= score + popcount(eaten), saturating at 2**SCORE_W-1.
  - pending <= 0; hit_pend <= 0.
  - Outputs update the cycle after the frame_start cycle (latency 1).
- Kill strobes for already-dead dots never add score. Repeated strobes of the same dot within one frame count once.
- FSM transitions:
  - IDLE -> PLAY on new_game. On entry: alive_10 = all ones, score = 0, pending = 0, hit_pend = 0.
  - PLAY -> LOSE at commit if hit_pend_next (ghost hit has priority over win).
  - PLAY -> WIN at commit if the post-commit alive mask is zero and there is no hit.
  - WIN/LOSE -> PLAY on new_game, with the same reinitialisation as IDLE -> PLAY. Score and mask are held until new_game.
  - new_game in PLAY is ignored.
- Outputs:
  - end_screen = (state==WIN) | (state==LOSE), registered.
  - game_state is registered.
- Simultaneous events:
  - frame_start and kill_10 in the same cycle: the kill belongs to the committing frame.
  - Eating the last dot and a ghost hit in the same frame resolves to LOSE, but score still includes that frame's dots.
- frame_start while not in PLAY: no effect.
- Reset mid-frame discards pending events.

Optional Feature:
- Macro DOT_LIVES_EN.
- Defined:
  - A hit at commit decrements lives.
  - If lives was 1, the FSM goes to LOSE with lives=0.
  - Otherwise it stays in PLAY, keeping alive_10 and score.
  - lives reloads to LIVES on every new game.
- Undefined:
  - Any hit goes to LOSE.
  - lives is tied to LIVES.

Decomposition:
- Package pacman_pkg holds:
  - typedef enum logic [1:0] game_state_t {IDLE, PLAY, WIN, LOSE}
  - localparams NUM_DOTS_DEF=10, SCORE_W_DEF=4.
- One natural sub-module: dot_popcount. Combinational count of set bits, parameterised by NUM_DOTS, output width SCORE_W.

Test Plan:
- Reset then new_game -> PLAY, alive_10=10'h3FF, score=0. Strobe kill_10=10'h005 for 5 cycles, then frame_start -> next cycle alive_10=10'h3FA, score=2.
- In PLAY, kill_10=10'h001 again plus kill_10=10'h002, frame_start -> alive_10 loses bit 1 only, score +1 (dead dot not rescored).
- Kill all remaining dots across frames -> on the final commit state=WIN, end_screen=1, score=10. kill_10 afterwards leaves the mask unchanged. new_game -> PLAY, alive_10=10'h3FF, score=0.
- Same frame: ghost_hit pulse plus last-dot kill, then frame_start -> state=LOSE, alive_10=0, score=10.
- DOT_LIVES_EN: three frames each with one ghost_hit -> lives 3→2→1 staying in PLAY, then LOSE with lives=0. Without the macro, the first hit -> LOSE.
- Assert Reset_n low mid-frame after kill_10=10'h3FF with no commit -> immediately alive_10=10'h3FF, score=0, state=IDLE. A later frame_start has no effect.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared game-state types and default sizing for the pacman video pipeline.
package pacman_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, WIN = 2'd2, LOSE = 2'd3} game_state_t;
    localparam int NUM_DOTS_DEF = 10;
    localparam int SCORE_W_DEF  = 4;
endpackage

// File: rtl/dot_popcount.sv
// Combinational set-bit count of a dot mask.
module dot_popcount #(
    parameter int NUM_DOTS = 10,
    parameter int SCORE_W  = 4
) (
    input  logic [NUM_DOTS-1:0] bits,
    output logic [SCORE_W-1:0]  count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_DOTS; i++)
            count = count + SCORE_W'(bits[i]);
    end
endmodule

// File: rtl/dot_tracker.sv
// Frame-committed dot/score/win-lose tracker. Define DOT_LIVES_EN to enable
// multi-life play; otherwise any ghost hit ends the game.
module dot_tracker
    import pacman_pkg::*;
#(
    parameter int NUM_DOTS = NUM_DOTS_DEF,
    parameter int SCORE_W  = SCORE_W_DEF,
    parameter int LIVES    = 3
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                frame_start,
    input  logic                new_game,
    input  logic [NUM_DOTS-1:0] kill_10,
    input  logic                ghost_hit,
    output logic [NUM_DOTS-1:0] alive_10,
    output logic [SCORE_W-1:0]  score,
    output logic [1:0]          game_state,
    output logic                end_screen,
    output logic [1:0]          lives
);
    game_state_t         state, state_nxt;
    logic [NUM_DOTS-1:0] alive_nxt, pend, pend_nxt, pend_acc, eaten;
    logic [SCORE_W-1:0]  score_nxt, eat_cnt;
    logic [SCORE_W:0]    score_sum;
    logic                hit_pend, hit_nxt, hit_acc, end_nxt;
    logic [1:0]          lives_q, lives_nxt;

    // Pending kills include this cycle's strobes so a kill on the frame_start
    // cycle lands in the committing frame.
    assign pend_acc  = pend | kill_10;
    assign hit_acc   = hit_pend | ghost_hit;
    assign eaten     = pend_acc & alive_10;
    assign score_sum = {1'b0, score} + {1'b0, eat_cnt};

    dot_popcount #(.NUM_DOTS(NUM_DOTS), .SCORE_W(SCORE_W)) u_popcount (
        .bits  (eaten),
        .count (eat_cnt)
    );

    always_comb begin
        state_nxt = state;
        alive_nxt = alive_10;
        score_nxt = score;
        pend_nxt  = pend;
        hit_nxt   = hit_pend;
        lives_nxt = lives_q;
        case (state)
            PLAY: begin
                pend_nxt = pend_acc;
                hit_nxt  = hit_acc;
                if (frame_start) begin
                    alive_nxt = alive_10 & ~eaten;
                    score_nxt = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                    pend_nxt  = '0;
                    hit_nxt   = 1'b0;
                    if (hit_acc) begin
`ifdef DOT_LIVES_EN
                        lives_nxt = lives_q - 2'd1;
                        if (lives_q <= 2'd1) begin
                            lives_nxt = 2'd0;
                            state_nxt = LOSE;
                        end
`else
                        state_nxt = LOSE;
`endif
                    end else if (alive_nxt == '0) begin
                        state_nxt = WIN;
                    end
                end
            end
            default: begin
                if (new_game) begin
                    state_nxt = PLAY;
                    alive_nxt = '1;
                    score_nxt = '0;
                    pend_nxt  = '0;
                    hit_nxt   = 1'b0;
                    lives_nxt = 2'(LIVES);
                end
            end
        endcase
        end_nxt = (state_nxt == WIN) || (state_nxt == LOSE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            alive_10   <= '1;
            score      <= '0;
            pend       <= '0;
            hit_pend   <= 1'b0;
            end_screen <= 1'b0;
            lives_q    <= 2'(LIVES);
        end else begin
            state      <= state_nxt;
            alive_10   <= alive_nxt;
            score      <= score_nxt;
            pend       <= pend_nxt;
            hit_pend   <= hit_nxt;
            end_screen <= end_nxt;
            lives_q    <= lives_nxt;
        end
    end

    assign game_state = state;
`ifdef DOT_LIVES_EN
    assign lives = lives_q;
`else
    // Lives register is still carried but the visible count is fixed.
    logic unused_lives;
    assign unused_lives = ^lives_q;
    assign lives = 2'(LIVES);
`endif
endmodule
